pd_prefetch: RTL and testbench
==============================

Name: pd_prefetch

Overview:
- Parametrised instruction prefetch queue placed in front of the P-D decoder.
- Buffers DEPTH words fetched over the W bus and tracks the fetch address.
- Presents the head instruction word, plus its argument word when the instruction carries one (C==0, normal-argument form), to the decoder together with the instruction's address.
- Replaces the single-word IR load path with a multi-word queue that supports flush on jump or invalidate.

Parameters:
- WIDTH, 16, data word width in bits; W bus and IR width.
- DEPTH, 4, queue depth in words; power of two, minimum 2.
- AWIDTH, 16, address width of the fetch and instruction-address counters.

Ports:
- clk_sys  in  1  system clock.
- clear  in  1  asynchronous active-high reset.
- push  in  1  fetched word valid on w this cycle.
- w  in  WIDTH  fetched word, MSB is bit 0.
- full  out  1  queue holds DEPTH words.
- fetch_addr  out  AWIDTH  address of the next word to fetch.
- flush  in  1  discard queue contents and reload addresses from pc_in (jump, SI1).
- pc_in  in  AWIDTH  new address, used only when flush=1.
- need_arg  in  1  from decoder, combinational on ir: head instruction takes the next word as its argument.
- pop  in  1  decoder consumes the head instruction.
- ir  out  WIDTH  head word.
- arg  out  WIDTH  word following the head.
- ir_valid  out  1  head word present.
- arg_valid  out  1  second word present.
- ready  out  1  ir_valid & (~need_arg | arg_valid).
- ir_addr  out  AWIDTH  address of the head word.
- count  out  clog2(DEPTH)+1  words held.
- ovf  out  1  sticky overflow error.

Behaviour:
- Reset (clear=1, asynchronous):
  - read and write pointers = 0, count = 0.
  - fetch_addr = 0, ir_addr = 0.
  - ovf = 0, full = 0, ir_valid = 0, arg_valid = 0, ready = 0.
  - ir and arg show the storage at the pointers; their value is don't-care while not valid.
  - clear mid-operation abandons all contents.
- Storage: circular buffer of DEPTH words. Pointers are clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. count = wr - rd.
- Combinational outputs:
  - ir = mem[rd], arg = mem[rd+1], both index bits taken modulo DEPTH.
  - ir_valid = count >= 1, arg_valid = count >= 2.
  - full = count == DEPTH.
- Pop (acted on at the clock edge):
  - Accepted only when pop & ready; otherwise ignored, with no state change.
  - Size = 2 when need_arg, else 1.
  - rd advances by size; ir_addr advances by size, wrapping modulo 2^AWIDTH.
- Push:
  - Accepted when count - popsize < DEPTH, so a push while full is accepted if a pop is accepted in the same cycle.
  - Accepted push: mem[wr] = w, wr advances by 1, fetch_addr advances by 1, wrapping modulo 2^AWIDTH.
  - Rejected push: word dropped, fetch_addr unchanged, ovf set to 1. ovf stays 1 until clear.
- Simultaneous pop and push: both take effect; count_next = count + push_acc - popsize.
- Flush (priority over push and pop in the same cycle):
  - rd = wr = 0, count = 0.
  - fetch_addr = pc_in, ir_addr = pc_in.
  - Any push in the flush cycle is discarded and does not set ovf.
- Latency: a pushed word appears on ir/arg one cycle after the push edge.
- Sequence invariant: ir_addr + count == fetch_addr (mod 2^AWIDTH) at all times outside reset.
- need_arg is sampled only when ready and pop are both high; its value while not ready is don't-care.

Optional Feature:
- Macro: PD_PREFETCH_BYPASS_EN.
- Defined: when count == 0, push = 1 and flush = 0:
  - ir = w and ir_valid = 1 in the same cycle.
  - If need_arg = 0 and pop = 1 in that cycle, the word is consumed directly: not written to the queue, ir_addr and fetch_addr both advance by 1, count stays 0.
  - arg is never bypassed, so a bypassed head with need_arg = 1 cannot be popped in that cycle and is stored normally.
- Undefined: no bypass; zero-cycle path from w to ir is absent; one-cycle latency always applies.

Test Plan:
- Fill and drain: after clear, flush with pc_in=0x0100, push 0x1111, 0x2222, 0x3333, 0x4444.
  - Expect full=1, fetch_addr=0x0104.
  - Pop four times with need_arg=0: ir sequence 0x1111 to 0x4444, ir_addr 0x0100 to 0x0103, count ends 0.
- Two-word instruction: queue holds one word 0xF000 with need_arg=1 and pop=1.
  - Expect ready=0, no change.
  - Push 0x00AB: next cycle ready=1, arg=0x00AB. Pop removes both words; ir_addr advances by 2.
- Overflow and full-with-pop:
  - DEPTH=4 full, push 0x5555 without pop: ovf=1, count=4, fetch_addr unchanged.
  - Push with pop (need_arg=0) while full: push accepted, count stays 4.
- Flush priority: count=3, assert flush, push and pop together with pc_in=0x7FFE.
  - Next cycle: count=0, ir_addr=fetch_addr=0x7FFE, ovf unchanged.
- Pointer and address wrap: flush with pc_in=0xFFFE, then 10 push/pop pairs.
  - Data order preserved; fetch_addr wraps 0xFFFF to 0x0000; ir_addr + count == fetch_addr throughout.
- Reset mid-operation: clear asserted asynchronously between edges with count=2.
  - All outputs reach reset values immediately.
  - With PD_PREFETCH_BYPASS_EN: empty queue, push 0x1234 with pop and need_arg=0 in the same cycle: ir=0x1234 that cycle, count stays 0, ir_addr increments.

Source files
------------

// File: rtl/pd_prefetch.sv
// pd_prefetch: instruction prefetch queue in front of the P-D decoder.
// Define PD_PREFETCH_BYPASS_EN to route w straight to ir while the queue is empty.
module pd_prefetch #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 16
) (
  input  logic                       clk_sys,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           w,
  output logic                       full,
  output logic [AWIDTH-1:0]          fetch_addr,
  input  logic                       flush,
  input  logic [AWIDTH-1:0]          pc_in,
  input  logic                       need_arg,
  input  logic                       pop,
  output logic [WIDTH-1:0]           ir,
  output logic [WIDTH-1:0]           arg,
  output logic                       ir_valid,
  output logic                       arg_valid,
  output logic                       ready,
  output logic [AWIDTH-1:0]          ir_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_rd, r_wr, w_cnt, w_rd1;
  logic [AWIDTH-1:0] r_fetch, r_iaddr;
  logic              r_ovf, w_byp, w_pop_acc, w_push_acc, w_consume;
  logic [1:0]        w_pops;
  logic [PW:0]       w_lim;
  always_comb begin
    w_cnt      = r_wr - r_rd;
    w_rd1      = r_rd + PW'(1);
`ifdef PD_PREFETCH_BYPASS_EN
    w_byp      = (w_cnt == '0) & push & ~flush;
`else
    w_byp      = 1'b0;
`endif
    ir_valid   = (w_cnt != '0) | w_byp;
    arg_valid  = w_cnt >= PW'(2);
    ready      = ir_valid & (~need_arg | arg_valid);
    w_pop_acc  = pop & ready;
    w_pops     = w_pop_acc ? (need_arg ? 2'd2 : 2'd1) : 2'd0;
    w_consume  = w_byp & w_pop_acc;
    // Room check allows a push into a full queue when a pop frees space the same cycle.
    w_lim      = (PW+1)'(DEPTH) + (PW+1)'(w_pops);
    w_push_acc = push & ({1'b0, w_cnt} < w_lim) & ~w_consume;
    ir         = w_byp ? w : r_mem[r_rd[IW-1:0]];
    arg        = r_mem[w_rd1[IW-1:0]];
    full       = w_cnt == PW'(DEPTH);
    count      = w_cnt;
    fetch_addr = r_fetch;
    ir_addr    = r_iaddr;
    ovf        = r_ovf;
  end
  always_ff @(posedge clk_sys or posedge clear) begin
    if (clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_fetch <= '0;
      r_iaddr <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_fetch <= pc_in;
      r_iaddr <= pc_in;
    end else begin
      r_rd    <= w_consume ? r_rd : r_rd + PW'(w_pops);
      r_iaddr <= r_iaddr + AWIDTH'(w_pops);
      if (w_push_acc | w_consume) r_fetch <= r_fetch + AWIDTH'(1);
      if (w_push_acc) r_wr <= r_wr + PW'(1);
      if (push & ~w_push_acc & ~w_consume) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk_sys)
    if (w_push_acc & ~flush) r_mem[r_wr[IW-1:0]] <= w;
endmodule

// File: tb/tb_pd_prefetch.sv
// tb_pd_prefetch: directed and randomized checks of pd_prefetch against a queue model.
module tb_pd_prefetch;
  localparam int DEPTH = 4;
  logic        clk_sys = 1'b0, clear = 1'b0, push = 1'b0, flush = 1'b0, need_arg = 1'b0, pop = 1'b0;
  logic [15:0] w = '0, pc_in = '0;
  logic        full, ir_valid, arg_valid, ready, ovf;
  logic [15:0] fetch_addr, ir, arg, ir_addr;
  logic [2:0]  count;
  int checks = 0, failures = 0;
  logic [15:0] mq[$];
  logic [15:0] m_fetch = '0, m_ia = '0;
  logic        m_ovf = 1'b0;

  pd_prefetch #(.WIDTH(16), .DEPTH(DEPTH), .AWIDTH(16)) dut (
    .clk_sys(clk_sys), .clear(clear), .push(push), .w(w), .full(full),
    .fetch_addr(fetch_addr), .flush(flush), .pc_in(pc_in), .need_arg(need_arg),
    .pop(pop), .ir(ir), .arg(arg), .ir_valid(ir_valid), .arg_valid(arg_valid),
    .ready(ready), .ir_addr(ir_addr), .count(count), .ovf(ovf)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle();
    push = 0; pop = 0; flush = 0; need_arg = 0; w = '0; pc_in = '0;
  endtask

  // Advance the model by the queue rules for the current inputs, then clock the DUT.
  task automatic tick();
    int n, pops;
    bit byp, rdy;
    n = mq.size();
    byp = 0;
`ifdef PD_PREFETCH_BYPASS_EN
    byp = (n == 0) && push && !flush;
`endif
    rdy = (n >= 1 && (!need_arg || n >= 2)) || (byp && !need_arg);
    pops = (pop && rdy) ? (need_arg ? 2 : 1) : 0;
    if (flush) begin
      mq.delete(); m_fetch = pc_in; m_ia = pc_in;
    end else if (byp && pops == 1) begin
      m_fetch = m_fetch + 16'd1; m_ia = m_ia + 16'd1;
    end else begin
      repeat (pops) void'(mq.pop_front());
      m_ia = m_ia + 16'(pops);
      if (push) begin
        if (n - pops < DEPTH) begin mq.push_back(w); m_fetch = m_fetch + 16'd1; end
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic model_clear();
    mq.delete(); m_fetch = '0; m_ia = '0; m_ovf = 0;
  endtask

  task automatic test_reset();
    clear = 1; #3;
    checks += 7;
    if (count !== 3'd0)       begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (fetch_addr !== 16'h0) begin failures++; $display("FAIL reset_fetch got=%h exp=0000", fetch_addr); end
    if (ir_addr !== 16'h0)    begin failures++; $display("FAIL reset_iraddr got=%h exp=0000", ir_addr); end
    if (ovf !== 1'b0)         begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (full !== 1'b0)        begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    if ({ir_valid, arg_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {ir_valid, arg_valid}); end
    if (ready !== 1'b0)       begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    @(posedge clk_sys); #3; clear = 0; model_clear();
    @(posedge clk_sys); #1;
  endtask

  task automatic test_fill_drain();
    logic [15:0] d [4];
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    idle(); flush = 1; pc_in = 16'h0100; tick(); idle();
    for (int i = 0; i < 4; i++) begin push = 1; w = d[i]; tick(); end
    idle(); #1;
    checks += 2;
    if (full !== 1'b1) begin failures++; $display("FAIL fd_full got=%b exp=1", full); end
    if (fetch_addr !== 16'h0104) begin failures++; $display("FAIL fd_fetch got=%h exp=0104", fetch_addr); end
    for (int i = 0; i < 4; i++) begin
      pop = 1; #1;
      checks += 2;
      if (ir !== d[i]) begin failures++; $display("FAIL fd_ir%0d got=%h exp=%h", i, ir, d[i]); end
      if (ir_addr !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL fd_iraddr%0d got=%h exp=%h", i, ir_addr, 16'h0100 + 16'(i)); end
      tick();
    end
    idle(); #1;
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL fd_count got=%0d exp=0", count); end
  endtask

  task automatic test_two_word();
    idle(); flush = 1; pc_in = 16'h0200; tick(); idle();
    push = 1; w = 16'hF000; tick(); idle();
    need_arg = 1; pop = 1; #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL tw_ready_lo got=%b exp=0", ready); end
    tick(); #1;
    checks += 2;
    if (count !== 3'd1) begin failures++; $display("FAIL tw_hold_count got=%0d exp=1", count); end
    if (ir_addr !== 16'h0200) begin failures++; $display("FAIL tw_hold_iraddr got=%h exp=0200", ir_addr); end
    pop = 0; push = 1; w = 16'h00AB; tick(); push = 0; pop = 1; #1;
    checks += 3;
    if (ready !== 1'b1) begin failures++; $display("FAIL tw_ready_hi got=%b exp=1", ready); end
    if (arg !== 16'h00AB) begin failures++; $display("FAIL tw_arg got=%h exp=00ab", arg); end
    if (ir !== 16'hF000) begin failures++; $display("FAIL tw_ir got=%h exp=f000", ir); end
    tick(); idle(); #1;
    checks += 2;
    if (ir_addr !== 16'h0202) begin failures++; $display("FAIL tw_iraddr got=%h exp=0202", ir_addr); end
    if (count !== 3'd0) begin failures++; $display("FAIL tw_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    idle(); flush = 1; pc_in = 16'h0300; tick(); idle();
    for (int i = 0; i < 4; i++) begin push = 1; w = 16'($urandom); tick(); end
    push = 1; w = 16'h5555; tick(); idle(); #1;
    checks += 3;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ov_ovf got=%b exp=1", ovf); end
    if (count !== 3'd4) begin failures++; $display("FAIL ov_count got=%0d exp=4", count); end
    if (fetch_addr !== 16'h0304) begin failures++; $display("FAIL ov_fetch got=%h exp=0304", fetch_addr); end
    push = 1; w = 16'h6666; pop = 1; tick(); idle(); #1;
    checks += 4;
    if (count !== 3'd4) begin failures++; $display("FAIL ovp_count got=%0d exp=4", count); end
    if (fetch_addr !== 16'h0305) begin failures++; $display("FAIL ovp_fetch got=%h exp=0305", fetch_addr); end
    if (ir_addr !== 16'h0301) begin failures++; $display("FAIL ovp_iraddr got=%h exp=0301", ir_addr); end
    if (ir !== mq[0]) begin failures++; $display("FAIL ovp_ir got=%h exp=%h", ir, mq[0]); end
  endtask

  task automatic test_flush_priority();
    idle(); pop = 1; tick(); idle(); #1;
    checks++;
    if (count !== 3'd3) begin failures++; $display("FAIL fp_pre_count got=%0d exp=3", count); end
    flush = 1; push = 1; pop = 1; w = 16'hBEEF; pc_in = 16'h7FFE; tick(); idle(); #1;
    checks += 4;
    if (count !== 3'd0) begin failures++; $display("FAIL fp_count got=%0d exp=0", count); end
    if (ir_addr !== 16'h7FFE) begin failures++; $display("FAIL fp_iraddr got=%h exp=7ffe", ir_addr); end
    if (fetch_addr !== 16'h7FFE) begin failures++; $display("FAIL fp_fetch got=%h exp=7ffe", fetch_addr); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL fp_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_wrap();
    idle(); flush = 1; pc_in = 16'hFFFE; tick(); idle();
    push = 1; w = 16'($urandom); tick();
    for (int i = 0; i < 10; i++) begin
      push = 1; pop = 1; need_arg = 0; w = 16'($urandom); #1;
      checks += 3;
      if (ir !== mq[0]) begin failures++; $display("FAIL wr_ir%0d got=%h exp=%h", i, ir, mq[0]); end
      if (fetch_addr !== m_fetch) begin failures++; $display("FAIL wr_fetch%0d got=%h exp=%h", i, fetch_addr, m_fetch); end
      if (16'(ir_addr + 16'(count)) !== fetch_addr) begin failures++; $display("FAIL wr_inv%0d got=%h exp=%h", i, 16'(ir_addr + 16'(count)), fetch_addr); end
      tick();
    end
    idle(); #1;
    checks += 2;
    if (fetch_addr !== 16'h0009) begin failures++; $display("FAIL wr_fetch_end got=%h exp=0009", fetch_addr); end
    if (ir_addr !== 16'h0008) begin failures++; $display("FAIL wr_iraddr_end got=%h exp=0008", ir_addr); end
  endtask

  task automatic test_random();
    int n;
    bit byp, e_iv, e_av, e_rdy;
    for (int c = 0; c < 400; c++) begin
      push = ($urandom_range(0, 9) < 6); pop = ($urandom_range(0, 9) < 6);
      need_arg = ($urandom_range(0, 9) < 3); flush = ($urandom_range(0, 49) == 0);
      w = 16'($urandom); pc_in = 16'($urandom);
      #1;
      n = mq.size();
      byp = 0;
`ifdef PD_PREFETCH_BYPASS_EN
      byp = (n == 0) && push && !flush;
`endif
      e_iv = (n >= 1) || byp; e_av = n >= 2; e_rdy = e_iv && (!need_arg || e_av);
      checks += 7;
      if (count !== 3'(n)) begin failures++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", c, count, n); end
      if (fetch_addr !== m_fetch) begin failures++; $display("FAIL rnd_fetch c%0d got=%h exp=%h", c, fetch_addr, m_fetch); end
      if (ir_addr !== m_ia) begin failures++; $display("FAIL rnd_iraddr c%0d got=%h exp=%h", c, ir_addr, m_ia); end
      if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf c%0d got=%b exp=%b", c, ovf, m_ovf); end
      if ({ir_valid, arg_valid} !== {e_iv, e_av}) begin failures++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, {ir_valid, arg_valid}, {e_iv, e_av}); end
      if (ready !== e_rdy) begin failures++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, ready, e_rdy); end
      if (full !== (n == DEPTH)) begin failures++; $display("FAIL rnd_full c%0d got=%b exp=%b", c, full, n == DEPTH); end
      if (e_iv) begin
        checks++;
        if (ir !== (byp ? w : mq[0])) begin failures++; $display("FAIL rnd_ir c%0d got=%h exp=%h", c, ir, byp ? w : mq[0]); end
      end
      if (e_av) begin
        checks++;
        if (arg !== mq[1]) begin failures++; $display("FAIL rnd_arg c%0d got=%h exp=%h", c, arg, mq[1]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_clear_async();
    idle(); flush = 1; pc_in = 16'h0400; tick(); idle();
    push = 1; w = 16'hAAAA; tick(); w = 16'hBBBB; tick(); idle(); #1;
    checks++;
    if (count !== 3'd2) begin failures++; $display("FAIL ca_pre_count got=%0d exp=2", count); end
    #1; clear = 1; #1;
    checks += 5;
    if (count !== 3'd0) begin failures++; $display("FAIL ca_count got=%0d exp=0", count); end
    if (fetch_addr !== 16'h0) begin failures++; $display("FAIL ca_fetch got=%h exp=0000", fetch_addr); end
    if (ir_addr !== 16'h0) begin failures++; $display("FAIL ca_iraddr got=%h exp=0000", ir_addr); end
    if ({ir_valid, arg_valid, ready, full} !== 4'b0) begin failures++; $display("FAIL ca_flags got=%b exp=0000", {ir_valid, arg_valid, ready, full}); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL ca_ovf got=%b exp=0", ovf); end
    #1; clear = 0; model_clear();
    @(posedge clk_sys); #1;
  endtask

`ifdef PD_PREFETCH_BYPASS_EN
  task automatic test_bypass();
    idle(); flush = 1; pc_in = 16'h0500; tick(); idle();
    push = 1; w = 16'h1234; pop = 1; need_arg = 0; #1;
    checks += 2;
    if (ir !== 16'h1234) begin failures++; $display("FAIL bp_ir got=%h exp=1234", ir); end
    if (ir_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", ir_valid); end
    tick(); idle(); #1;
    checks += 3;
    if (count !== 3'd0) begin failures++; $display("FAIL bp_count got=%0d exp=0", count); end
    if (ir_addr !== 16'h0501) begin failures++; $display("FAIL bp_iraddr got=%h exp=0501", ir_addr); end
    if (fetch_addr !== 16'h0501) begin failures++; $display("FAIL bp_fetch got=%h exp=0501", fetch_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_two_word();
    test_overflow();
    test_flush_priority();
    test_wrap();
    test_random();
    test_clear_async();
`ifdef PD_PREFETCH_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
